// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared constants and state encoding for encoder_scan
package enc_pkg;
  localparam int N_IN   = 8;
  localparam int W_CODE = $clog2(N_IN);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;
endpackage

// File: rtl/encoder_scan_bit_pick.sv
// rtl/encoder_scan_bit_pick.sv - selects the next set bit of a vector (index, one-hot mask, single-bit flag)
// Scan direction follows ENCODER_SCAN_MSB_FIRST_EN (lowest bit first when undefined).
module bit_pick
  import enc_pkg::*;
(
  input  logic [N_IN-1:0]   i_vec,
  output logic [W_CODE-1:0] o_idx,
  output logic              o_single,
  output logic [N_IN-1:0]   o_mask
);

  logic w_any;

  assign w_any = (i_vec != '0);

  // Last match in loop order wins, so iterate toward the preferred end.
  always_comb begin
    o_idx = '0;
`ifdef ENCODER_SCAN_MSB_FIRST_EN
    for (int i = 0; i < N_IN; i++) begin
      if (i_vec[i]) o_idx = W_CODE'(i);
    end
`else
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W_CODE'(i);
    end
`endif
  end

  assign o_mask   = w_any ? (N_IN'(1) << o_idx) : '0;
  assign o_single = w_any && ((i_vec & (i_vec - N_IN'(1))) == '0);

endmodule

// File: rtl/encoder_scan.sv
// rtl/encoder_scan.sv - sequential 8-to-3 encoder emitting one code per set bit of a captured vector
// Optional ENCODER_SCAN_MSB_FIRST_EN reverses the scan order (highest bit first).
module encoder_scan
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_CODE-1:0] out_code,
  output logic              out_last,
  output logic              zero_err,
  output logic              busy
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [N_IN-1:0]     r_pending;
  logic [N_IN-1:0]     w_pending_nxt;
  logic                r_zero_err;
  logic                w_zero_err_nxt;
  logic [W_CODE-1:0]   w_idx;
  logic                w_single;
  logic [N_IN-1:0]     w_mask;

  bit_pick u_pick (
    .i_vec    (r_pending),
    .o_idx    (w_idx),
    .o_single (w_single),
    .o_mask   (w_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pending  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_zero_err <= w_zero_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pending_nxt  = r_pending;
    w_zero_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          if (in_vec != '0) begin
            w_pending_nxt = in_vec;
            w_state_nxt   = ST_EMIT;
          end else begin
            w_zero_err_nxt = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          w_pending_nxt = r_pending & ~w_mask;
          if (w_single) begin
            w_pending_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = '0;
      end
    endcase
  end

  // Gating with rst_n keeps in_ready low for the whole reset assertion.
  assign in_ready  = rst_n && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_EMIT);
  assign busy      = (r_state == ST_EMIT);
  assign out_code  = w_idx;
  assign out_last  = out_valid && w_single;
  assign zero_err  = r_zero_err;

endmodule

// File: tb/tb_encoder_scan.sv
// tb/tb_encoder_scan.sv - randomized scoreboard bench for encoder_scan
module tb_encoder_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_vec = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_code;
  logic       out_last;
  logic       zero_err;
  logic       busy;

  encoder_scan dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_last  (out_last),
    .zero_err  (zero_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         zexp = -1;
  int         hs_cnt = 0;
  int         rdy_mode = 1;
  logic [3:0] exp_q[$];
  logic [3:0] held;
  logic       held_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: list set bits in scan order; the final one carries last=1.
  function automatic void model_push(input logic [7:0] v);
    int n = 0;
    int total = $countones(v);
    for (int k = 0; k < 8; k++) begin
`ifdef ENCODER_SCAN_MSB_FIRST_EN
      int i = 7 - k;
`else
      int i = k;
`endif
      if (v[i]) begin
        logic [2:0] c;
        n++;
        c = i[2:0];
        exp_q.push_back({(n == total), c});
      end
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = ($urandom_range(0, 9) < 7);
      1: out_ready = 1'b1;
      default: out_ready = ~out_ready;
    endcase
  end

  // Monitor: a vector is "in flight" exactly while its codes sit in the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      chk("busy", busy, exp_q.size() != 0);
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("in_ready", in_ready, exp_q.size() == 0);
      chk("zero_err", zero_err, cyc == zexp);
      if (held_v && out_valid) chk("hold", {out_last, out_code}, held);
      held_v = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_code", 1, 0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          chk("code", out_code, e[2:0]);
          chk("last", out_last, e[3]);
        end
        hs_cnt++;
      end else if (out_valid) begin
        held   = {out_last, out_code};
        held_v = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the capture edge.
  task automatic send(input logic [7:0] v);
    int t = 0;
    in_valid = 1'b1;
    in_vec   = v;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      tick();
      if (v != 8'h00) model_push(v);
      else zexp = cyc;
    end
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) chk("drain_timeout", 0, 1);
  endtask

  initial begin
    int h0;
    int t;
    logic [7:0] v;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zero_err", zero_err, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("ready_after_reset", in_ready, 1);

    rdy_mode = 1;
    send(8'b0000_0100);
    chk("onehot_valid", out_valid, 1);
    chk("onehot_code", out_code, 2);
    chk("onehot_last", out_last, 1);
    tick();
    chk("onehot_idle_ready", in_ready, 1);

    send(8'b1010_0010);
    drain();

    rdy_mode = 2;
    h0 = hs_cnt;
    send(8'hFF);
    drain();
    chk("ff_handshakes", hs_cnt - h0, 8);
    chk("ff_busy_low", busy, 0);
    rdy_mode = 1;

    send(8'h00);
    tick();
    drain();

    send(8'h03);
    send(8'h80);
    drain();

    h0 = hs_cnt;
    send(8'h0F);
    t = 0;
    while (hs_cnt < h0 + 2 && t < 50) begin
      tick();
      t++;
    end
    chk("midscan_reached", hs_cnt - h0, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_in_ready", in_ready, 0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    h0 = hs_cnt;
    repeat (5) tick();
    chk("post_reset_no_codes", hs_cnt - h0, 0);

    rdy_mode = 0;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: v = 8'h01 << $urandom_range(0, 7);
        1: v = 8'h00;
        default: v = 8'($urandom);
      endcase
      send(v);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    rdy_mode = 1;
    repeat (3) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder_scan.md
Name: encoder_scan

Overview:
Sequential 8-to-3 encoder; the inverse of the team's 3-to-8 decoder.
- Accepts an 8-bit request vector over a valid/ready handshake and captures it.
- Emits the 3-bit index of every set bit, one code per output handshake, lowest index first by default.
- Sits between request sources (one-hot or multi-hot lines) and any consumer that needs binary codes, e.g. a decoder-driven select bus.

Parameters:
- N_IN, 8, width of the request vector. Fixed at 8 for this revision.
- W_CODE, 3, code width. Equals clog2(N_IN); local constant, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request vector present
- in_ready  output  1  block can capture a vector
- in_vec  input  8  request vector; bit i maps to code i (bit 0 corresponds to decoder output out1)
- out_valid  output  1  out_code is valid
- out_ready  input  1  consumer accepts out_code
- out_code  output  3  index of the currently selected set bit
- out_last  output  1  current code is the final one for the captured vector
- zero_err  output  1  one-cycle pulse: an all-zero vector was accepted
- busy  output  1  high while a captured vector still has codes pending

Behaviour:
- Reset (asynchronous, rst_n low): takes effect immediately, not at the next clock edge.
  - state=IDLE, pending=0.
  - out_valid=0, out_code=0, out_last=0, zero_err=0, busy=0, in_ready=0 while rst_n is low.
  - in_ready rises in the first cycle after rst_n deasserts.
  - Reset mid-scan discards remaining codes; nothing is emitted after release.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1, busy=1.
- Capture in IDLE, on in_valid&&in_ready at edge k:
  - in_vec!=0: pending<=in_vec; state->EMIT; out_valid=1 from cycle k+1 (1-cycle latency).
  - in_vec==0: vector dropped; zero_err=1 for exactly cycle k+1; state stays IDLE.
- EMIT outputs:
  - out_code = index of lowest set bit of pending (combinational from the pending register, so it is stable while out_valid=1).
  - out_last = 1 when pending has exactly one bit set.
- EMIT handshake, out_valid&&out_ready at an edge:
  - The emitted bit is cleared in pending.
  - If out_last was 1: state->IDLE, pending=0.
  - Otherwise: stay in EMIT; the next code is presented the following cycle with no bubble.
- Backpressure: out_ready=0 holds out_code and out_last unchanged indefinitely.
- in_vec and in_valid are ignored outside IDLE; the producer must hold them until in_ready.
- Throughput: a vector with m set bits takes m cycles in EMIT plus 1 IDLE cycle before the next capture. Worst case 0xFF = 8 codes, 9 cycles.
- One-hot input yields a single code with out_last=1, i.e. a registered 8-to-3 encoder.
- No wrap-around: the scan terminates on the last set bit and never revisits cleared bits.
- All state and pending registers update only on the clk rising edge, apart from the asynchronous reset.

Optional Feature:
- Macro: ENCODER_SCAN_MSB_FIRST_EN
- Defined: the scan order is reversed. out_code = index of the highest set bit of pending; the handshake clears that bit. out_last is unchanged (exactly one bit remaining). All timing is unchanged.
- Undefined: LSB-first order as described above.

Decomposition:
- Shared package enc_pkg holds:
  - N_IN=8, W_CODE=3
  - state encodings ST_IDLE=1'b0, ST_EMIT=1'b1
- Sub-module bit_pick: combinational.
  - Input: 8-bit vector. Outputs: 3-bit index of the selected set bit, 1-bit "single bit set" flag, 8-bit one-hot mask of the selected bit.
  - Its direction follows ENCODER_SCAN_MSB_FIRST_EN.
  - encoder_scan instantiates it once on pending and clears bits with pending & ~mask.

Test Plan:
- Reset, then in_vec=8'b0000_0100 with in_valid=1 and out_ready=1:
  - Cycle after capture: out_valid=1, out_code=3'd2, out_last=1.
  - Next cycle: IDLE, in_ready=1.
- in_vec=8'b1010_0010 with out_ready=1:
  - Codes 1, 5, 7 on consecutive cycles; out_last=1 only on code 7.
  - With ENCODER_SCAN_MSB_FIRST_EN defined: codes 7, 5, 1; out_last only on code 1.
- in_vec=8'hFF with out_ready toggling 1,0,1,0:
  - Codes 0..7 each held while out_ready=0; exactly 8 handshakes; busy falls after code 7.
- in_vec=8'h00 with in_valid=1:
  - zero_err=1 for one cycle; out_valid stays 0; in_ready stays 1.
- Reset mid-operation: in_vec=8'h0F, rst_n pulled low after the handshake for code 1:
  - out_valid=0 and busy=0 immediately, asynchronously.
  - After release: IDLE with no further codes emitted.
- in_vec changes to 8'h80 with in_valid=1 while in EMIT on 8'h03:
  - Ignored; only codes 0 and 1 are emitted.
  - 8'h80 (still held) is captured in the following IDLE cycle and yields code 7.
